cv32e41s_tcm_arbiter: RTL and testbench
=======================================

Name: cv32e41s_tcm_arbiter

Overview:
Shares one TCM port between two OBI requesters: m0 is the core data/instruction path, m1 is the debug or loader path.
- Round-robin arbitration, single-cycle address phase.
- Routes each 1-cycle-latency TCM response back to the master that issued the request.
- Answers out-of-range accesses locally with an error response; these never reach the TCM.
- Sits between the requesters and one port (A or B) of the TCM.

Parameters:
TCM_BASE, 32'h0000_0000, byte base address of the TCM window
MEM_SIZE, 1024, TCM depth in 32-bit words; window is [TCM_BASE, TCM_BASE+4*MEM_SIZE)
RESET_PRIO, 0, master that holds priority after reset (0 or 1)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
m{0,1}_req_i  input  1  OBI address-phase request
m{0,1}_gnt_o  output  1  OBI grant (combinational)
m{0,1}_addr_i  input  32  byte address
m{0,1}_we_i  input  1  write enable
m{0,1}_be_i  input  4  byte enables
m{0,1}_wdata_i  input  32  write data
m{0,1}_rvalid_o  output  1  response valid
m{0,1}_rdata_o  output  32  read data
m{0,1}_err_o  output  1  response error (out-of-range address)
tcm_req_o  output  1  TCM enable
tcm_we_o  output  1  TCM write enable
tcm_be_o  output  4  TCM byte enables
tcm_addr_o  output  32  byte offset, equal to addr - TCM_BASE
tcm_wdata_o  output  32  TCM write data
tcm_rvalid_i  input  1  TCM response valid, exactly 1 cycle after tcm_req_o
tcm_rdata_i  input  32  TCM read data

Behaviour:
- Reset: all outputs 0; prio_q = RESET_PRIO; rsp_valid_q = 0; rsp_err_q = 0; rsp_id_q = 0.
- Arbitration (combinational):
  - One master requesting: it wins.
  - Both requesting: master prio_q wins.
  - Exactly one gnt per cycle; gnt is asserted in the same cycle as req.
- Priority update: on every cycle with both masters requesting, prio_q <= loser. Otherwise prio_q holds. Guarantees no starvation, worst case 1 lost cycle.
- In range: a granted request with TCM_BASE <= addr < TCM_BASE+4*MEM_SIZE drives tcm_req_o=1 and forwards we/be/wdata with offset address.
- Out of range: the request is still granted, but tcm_req_o stays 0 and rsp_err_q <= 1 for that cycle.
- Idle cycle: tcm_req_o = 0; tcm_we_o/be_o/addr_o/wdata_o = 0.
- Response tracking registers, updated every cycle:
  - rsp_valid_q <= any grant
  - rsp_id_q <= winner
  - rsp_err_q <= granted && out-of-range
- Response cycle (1 cycle after grant):
  - m[rsp_id_q]_rvalid_o = rsp_valid_q.
  - rdata = tcm_rdata_i, or 0 when err.
  - err = rsp_err_q.
  - The other master sees rvalid = 0 and rdata = 0.
- Back-to-back: a new grant is allowed every cycle while the previous response is returned. At most 1 transaction is outstanding per cycle stage, so no FIFO is needed.
- Integrity check: tcm_rvalid_i must equal rsp_valid_q && !rsp_err_q.
  - Mismatch is flagged by an assertion (simulation only).
  - On mismatch, the arbiter still uses its own rsp_valid_q.
- Writes produce a response (rvalid, rdata = 0 or TCM value), consistent with OBI.
- Reset mid-operation: in-flight responses are discarded; no rvalid after reset deasserts until a new grant.
- Address edges: TCM_BASE+4*MEM_SIZE-4 is in range; TCM_BASE+4*MEM_SIZE is out of range. Range compare is done at 33 bits to avoid wrap at 2^32.

Decomposition:
- Shared package cv32e41s_tcm_pkg holds:
  - obi_req_t (req, we, be, addr, wdata)
  - obi_rsp_t (rvalid, rdata, err)
  - N_MASTERS = 2
  - the 33-bit range-check function
- One sub-module: cv32e41s_rr_arbiter_2 (prio register plus grant logic), reusable for the instruction side.

Test Plan:
- m0 only, read 0x10 (TCM holds 0xDEADBEEF) -> m0_gnt=1 same cycle, tcm_addr=0x10; next cycle m0_rvalid=1, rdata=0xDEADBEEF, err=0.
- Both request for 4 consecutive cycles, RESET_PRIO=0 -> grants m0,m1,m0,m1; responses routed to the matching master each following cycle.
- m1 writes be=4'b0011, wdata=0x12345678 to 0x20, then m0 reads 0x20 (old value 0xAAAAAAAA) -> rdata 0xAAAA5678.
- m0 reads TCM_BASE+4*MEM_SIZE -> gnt=1, tcm_req=0, next cycle rvalid=1, err=1, rdata=0; last word TCM_BASE+4*MEM_SIZE-4 returns err=0.
- Grant at cycle N, rst_ni low at N+0.5 -> all outputs 0, no rvalid after release; prio returns to RESET_PRIO.

Source files
------------

// File: rtl/cv32e41s_tcm_pkg.sv
// Shared types and helpers for the TCM arbiter slice.
// Holds the OBI request/response structs and the 33-bit window check.
package cv32e41s_tcm_pkg;

  localparam int unsigned N_MASTERS = 2;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // Done at 33 bits so a window ending exactly at 2^32 does not wrap to zero.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size_words);
    logic [32:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + ({1'b0, size_words} << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/cv32e41s_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant, priority flips to the
// loser on every contended cycle.
module cv32e41s_rr_arbiter_2 #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       id_o
);

  localparam logic RST_PRIO = (RESET_PRIO != 0);

  logic prio_q, prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    id_o   = 1'b0;
    unique case (req_i)
      2'b01: begin gnt_o = 2'b01; id_o = 1'b0; end
      2'b10: begin gnt_o = 2'b10; id_o = 1'b1; end
      2'b11: begin gnt_o = prio_q ? 2'b10 : 2'b01; id_o = prio_q; end
      default: ;
    endcase
    prio_d = (&req_i) ? ~id_o : prio_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= RST_PRIO;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/cv32e41s_tcm_arbiter.sv
// Shares one TCM port between two OBI masters; out-of-window accesses are
// answered locally with err and never reach the TCM.
module cv32e41s_tcm_arbiter
  import cv32e41s_tcm_pkg::*;
#(
  parameter logic [31:0] TCM_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        tcm_req_o,
  output logic        tcm_we_o,
  output logic [3:0]  tcm_be_o,
  output logic [31:0] tcm_addr_o,
  output logic [31:0] tcm_wdata_o,
  input  logic        tcm_rvalid_i,
  input  logic [31:0] tcm_rdata_i
);

  obi_req_t [N_MASTERS-1:0] mreq;
  obi_rsp_t [N_MASTERS-1:0] mrsp;
  logic     [N_MASTERS-1:0] req_vec, gnt;
  obi_req_t                 sel;
  logic                     win_id, any_gnt, in_rng, tcm_fire;
  logic                     rsp_valid_q, rsp_id_q, rsp_err_q;

  // Requests are masked while in reset so every output reads 0.
  assign mreq[0] = '{req: m0_req_i & rst_ni, we: m0_we_i, be: m0_be_i,
                     addr: m0_addr_i, wdata: m0_wdata_i};
  assign mreq[1] = '{req: m1_req_i & rst_ni, we: m1_we_i, be: m1_be_i,
                     addr: m1_addr_i, wdata: m1_wdata_i};

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_req
    assign req_vec[i] = mreq[i].req;
  end

  cv32e41s_rr_arbiter_2 #(
    .RESET_PRIO (RESET_PRIO)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_vec),
    .gnt_o  (gnt),
    .id_o   (win_id)
  );

  assign sel      = mreq[win_id];
  assign any_gnt  = |gnt;
  assign in_rng   = addr_in_range(sel.addr, TCM_BASE, 32'(MEM_SIZE));
  assign tcm_fire = any_gnt & in_rng;

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign tcm_req_o   = tcm_fire;
  assign tcm_we_o    = tcm_fire & sel.we;
  assign tcm_be_o    = tcm_fire ? sel.be : 4'b0000;
  assign tcm_addr_o  = tcm_fire ? (sel.addr - TCM_BASE) : 32'h0;
  assign tcm_wdata_o = tcm_fire ? sel.wdata : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_id_q    <= win_id;
      rsp_err_q   <= any_gnt & ~in_rng;
    end
  end

  // Only the master that owned the grant sees the response.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_rsp
    logic hit;
    assign hit           = rsp_valid_q && (rsp_id_q == 1'(i));
    assign mrsp[i].rvalid = hit;
    assign mrsp[i].err    = hit & rsp_err_q;
    assign mrsp[i].rdata  = (hit & ~rsp_err_q) ? tcm_rdata_i : 32'h0;
  end

  assign m0_rvalid_o = mrsp[0].rvalid;
  assign m0_rdata_o  = mrsp[0].rdata;
  assign m0_err_o    = mrsp[0].err;
  assign m1_rvalid_o = mrsp[1].rvalid;
  assign m1_rdata_o  = mrsp[1].rdata;
  assign m1_err_o    = mrsp[1].err;

`ifndef SYNTHESIS
  // The TCM's own rvalid is not trusted for routing, only cross-checked.
  a_tcm_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tcm_rvalid_i == (rsp_valid_q && !rsp_err_q));
`endif

endmodule

// File: tb/tb_cv32e41s_tcm_arbiter.sv
// Randomized bench for the TCM arbiter against a transaction-level model
// with its own shadow memory and a registered TCM stand-in.
module tb_cv32e41s_tcm_arbiter;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned SIZE = 1024;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rq [2];
  logic        wr [2];
  logic [3:0]  be [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];

  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        tcm_req_o, tcm_we_o, tcm_rvalid_i;
  logic [3:0]  tcm_be_o;
  logic [31:0] tcm_addr_o, tcm_wdata_o, tcm_rdata_i;

  cv32e41s_tcm_arbiter #(.TCM_BASE(BASE), .MEM_SIZE(SIZE), .RESET_PRIO(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(rq[0]), .m0_gnt_o(m0_gnt_o), .m0_addr_i(ad[0]), .m0_we_i(wr[0]),
    .m0_be_i(be[0]), .m0_wdata_i(wd[0]), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(rq[1]), .m1_gnt_o(m1_gnt_o), .m1_addr_i(ad[1]), .m1_we_i(wr[1]),
    .m1_be_i(be[1]), .m1_wdata_i(wd[1]), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .tcm_req_o(tcm_req_o), .tcm_we_o(tcm_we_o), .tcm_be_o(tcm_be_o),
    .tcm_addr_o(tcm_addr_o), .tcm_wdata_o(tcm_wdata_o),
    .tcm_rvalid_i(tcm_rvalid_i), .tcm_rdata_i(tcm_rdata_i)
  );

  // TCM stand-in: 1-cycle read latency, byte-enabled writes, writes return 0.
  logic [31:0] tmem [SIZE];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcm_rvalid_i <= 1'b0;
      tcm_rdata_i  <= 32'h0;
    end else begin
      tcm_rvalid_i <= tcm_req_o;
      if (tcm_req_o) begin
        if (tcm_we_o) begin
          for (int k = 0; k < 4; k++)
            if (tcm_be_o[k]) tmem[tcm_addr_o[11:2]][8*k +: 8] <= tcm_wdata_o[8*k +: 8];
          tcm_rdata_i <= 32'h0;
        end else begin
          tcm_rdata_i <= tmem[tcm_addr_o[11:2]];
        end
      end
    end
  end

  // Reference model state
  logic [31:0] shadow [SIZE];
  int          prio;
  bit          p_v, p_err;
  int          p_id;
  logic [31:0] p_data;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint la = longint'(a), lo = longint'(BASE), hi = longint'(BASE) + 4 * longint'(SIZE);
    return (la >= lo) && (la < hi);
  endfunction

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; wr[i] = 0; be[i] = 0; ad[i] = 0; wd[i] = 0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  {30'b0, m1_gnt_o, m0_gnt_o}, 32'h0);
    chk({tag, "_tcm"},  {25'b0, tcm_req_o, tcm_we_o, tcm_be_o}, 32'h0);
    chk({tag, "_taddr"}, tcm_addr_o, 32'h0);
    chk({tag, "_twd"},  tcm_wdata_o, 32'h0);
    chk({tag, "_rsp"},  {28'b0, m1_rvalid_o, m1_err_o, m0_rvalid_o, m0_err_o}, 32'h0);
    chk({tag, "_rd0"},  m0_rdata_o, 32'h0);
    chk({tag, "_rd1"},  m1_rdata_o, 32'h0);
  endtask

  // Entered at posedge+1 with inputs already set; checks, then advances one cycle.
  task automatic step();
    int win;
    bit inr;
    logic [31:0] a, off;
    win = -1;
    if (rq[0] && rq[1]) win = prio;
    else if (rq[0])     win = 0;
    else if (rq[1])     win = 1;
    inr = (win >= 0) && in_win(ad[win >= 0 ? win : 0]);
    a   = ad[win >= 0 ? win : 0];
    off = a - BASE;
    #3;
    chk("gnt0", {31'b0, m0_gnt_o}, {31'b0, win == 0});
    chk("gnt1", {31'b0, m1_gnt_o}, {31'b0, win == 1});
    chk("tcm_req", {31'b0, tcm_req_o}, {31'b0, inr});
    chk("tcm_we", {31'b0, tcm_we_o}, {31'b0, inr && wr[win]});
    chk("tcm_be", {28'b0, tcm_be_o}, inr ? {28'b0, be[win]} : 32'h0);
    chk("tcm_addr", tcm_addr_o, inr ? off : 32'h0);
    chk("tcm_wdata", tcm_wdata_o, inr ? wd[win] : 32'h0);
    chk("rvalid0", {31'b0, m0_rvalid_o}, {31'b0, p_v && p_id == 0});
    chk("rvalid1", {31'b0, m1_rvalid_o}, {31'b0, p_v && p_id == 1});
    chk("err0", {31'b0, m0_err_o}, {31'b0, p_v && p_id == 0 && p_err});
    chk("err1", {31'b0, m1_err_o}, {31'b0, p_v && p_id == 1 && p_err});
    chk("rdata0", m0_rdata_o, (p_v && p_id == 0 && !p_err) ? p_data : 32'h0);
    chk("rdata1", m1_rdata_o, (p_v && p_id == 1 && !p_err) ? p_data : 32'h0);
    @(posedge clk_i);
    if (rq[0] && rq[1]) prio = 1 - win;
    p_v = (win >= 0); p_id = (win >= 0) ? win : 0; p_err = (win >= 0) && !inr; p_data = 32'h0;
    if (inr) begin
      if (wr[win]) begin
        for (int k = 0; k < 4; k++)
          if (be[win][k]) shadow[off[11:2]][8*k +: 8] = wd[win][8*k +: 8];
      end else begin
        p_data = shadow[off[11:2]];
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return BASE + 4 * SIZE;
      1: return BASE + 4 * SIZE - 4;
      2: return BASE - 4;
      3: return {$urandom} & 32'hFFFF_FFFC;
      default: return BASE + 4 * $urandom_range(0, 63);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      tmem[i] = $urandom; shadow[i] = tmem[i];
    end
    tmem[4] = 32'hDEAD_BEEF; shadow[4] = 32'hDEAD_BEEF;
    tmem[8] = 32'hAAAA_AAAA; shadow[8] = 32'hAAAA_AAAA;
    prio = 0; p_v = 0; p_err = 0; p_id = 0; p_data = 0;
    set_idle();
    repeat (2) @(posedge clk_i);
    #1 chk_all_zero("reset");
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single read from m0
    rq[0] = 1; ad[0] = BASE + 32'h10;
    step();
    chk("dead_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    set_idle(); step();

    // Contention: alternating grants starting with m0
    repeat (4) begin
      rq[0] = 1; rq[1] = 1; ad[0] = BASE + 32'h40; ad[1] = BASE + 32'h44; step();
    end
    set_idle(); step();

    // Partial write from m1 then read back from m0
    rq[1] = 1; wr[1] = 1; be[1] = 4'b0011; wd[1] = 32'h1234_5678; ad[1] = BASE + 32'h20;
    step(); set_idle();
    rq[0] = 1; ad[0] = BASE + 32'h20;
    step();
    chk("rmw_rdata", m0_rdata_o, 32'hAAAA_5678);
    set_idle(); step();

    // Window edges
    rq[0] = 1; ad[0] = BASE + 4 * SIZE; step();
    chk("oor_err", {31'b0, m0_err_o}, 32'h1);
    rq[0] = 1; ad[0] = BASE + 4 * SIZE - 4; step();
    chk("last_err", {31'b0, m0_err_o}, 32'h0);
    set_idle(); step();

    // Reset with a response in flight; leave prio at m1 first
    rq[0] = 1; rq[1] = 1; ad[0] = BASE; ad[1] = BASE + 4; step();
    set_idle(); rq[0] = 1; ad[0] = BASE + 8; step();
    set_idle();
    #4 rst_ni = 1'b0;
    #1 chk_all_zero("midrst");
    prio = 0; p_v = 0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    step();
    rq[0] = 1; rq[1] = 1; ad[0] = BASE; ad[1] = BASE + 4; step();
    set_idle(); step();

    // Randomized traffic
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        rq[i] = ($urandom_range(0, 3) != 0);
        wr[i] = $urandom_range(0, 1);
        be[i] = 4'($urandom);
        wd[i] = $urandom;
        ad[i] = rand_addr();
      end
      step();
    end
    set_idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
